pipe_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline (F/D/E/M/W). Takes hazard requests (load-use, load->store RS1), branch

---
 rtl/pipe_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage F/D/E/M/W core: stage enables, bubbles and flushes.
// Define PERF_CNT_EN to add the STALL_CNT / FLUSH_CNT / MWAIT_CNT performance counters.
module pipe_ctrl #(
    parameter int unsigned LU_STALL_CYC = 1,
    parameter int unsigned MEM_TMO      = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LU_HAZ,
    input  logic             BR_TAKEN,
    input  logic             IMEM_RDY,
    input  logic             DMEM_REQ,
    input  logic             DMEM_ACK,
    output logic             PC_EN,
    output logic             FD_EN,
    output logic             DE_EN,
    output logic             EM_EN,
    output logic             MW_EN,
    output logic             FD_FLUSH,
    output logic             DE_FLUSH,
    output logic             MEM_ERR,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT,
    output logic [CNT_W-1:0] MWAIT_CNT,
`endif
    output logic             BUSY
);

    if (LU_STALL_CYC < 1 || LU_STALL_CYC > 3 || CNT_W == 0) begin : g_bad_param
        $error("pipe_ctrl: LU_STALL_CYC must be 1..3 and CNT_W nonzero");
    end

    localparam int unsigned WD_W = (MEM_TMO > 1) ? $clog2(MEM_TMO + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TMO);
    localparam logic [WD_W-1:0] WD_HIT = WD_W'((MEM_TMO == 0) ? 0 : MEM_TMO - 1);

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MEM_WAIT
    } state_t;

    state_t          state;
    logic [1:0]      cnt;
    logic            resume;
    logic [WD_W-1:0] wd;
    logic            err_q;

    logic            mem_stall;
    logic            lu_req;
    logic            tmo_hit;
    logic [1:0]      lu_next_cnt;

    always_comb begin
        mem_stall   = DMEM_REQ & ~DMEM_ACK;
        lu_req      = (state == LU_STALL) | ((state == RUN) & LU_HAZ);
        tmo_hit     = (MEM_TMO != 0) && mem_stall && (wd == WD_HIT);
        lu_next_cnt = (state == RUN) ? 2'(LU_STALL_CYC - 1) : cnt - 2'd1;
    end

    always_comb begin
        PC_EN    = 1'b1;
        FD_EN    = 1'b1;
        DE_EN    = 1'b1;
        EM_EN    = 1'b1;
        MW_EN    = 1'b1;
        FD_FLUSH = 1'b0;
        DE_FLUSH = 1'b0;
        if (RST) begin
            {PC_EN, FD_EN, DE_EN, EM_EN, MW_EN} = '0;
            FD_FLUSH = 1'b1;
            DE_FLUSH = 1'b1;
        end else if (mem_stall) begin
            {PC_EN, FD_EN, DE_EN, EM_EN, MW_EN} = '0;
        end else if (BR_TAKEN) begin
            FD_FLUSH = 1'b1;
            DE_FLUSH = 1'b1;
        end else if (state == MEM_WAIT) begin
            // ACK cycle: everything advances once before any resumed load-use stall
            FD_FLUSH = 1'b0;
        end else if (lu_req) begin
            PC_EN    = 1'b0;
            FD_EN    = 1'b0;
            DE_FLUSH = 1'b1;
        end else if (!IMEM_RDY) begin
            PC_EN    = 1'b0;
            FD_FLUSH = 1'b1;
        end
    end

    assign MEM_ERR = ~RST & (err_q | tmo_hit);
    assign BUSY    = (state != RUN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= RUN;
            cnt    <= '0;
            resume <= 1'b0;
            wd     <= '0;
            err_q  <= 1'b0;
        end else begin
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
            if (mem_stall) begin
                if (wd != WD_MAX) begin
                    wd <= wd + 1'b1;
                end
                // a pre-empted load-use stall keeps its count frozen until the wait ends
                if (state == LU_STALL) begin
                    resume <= 1'b1;
                end
                state <= MEM_WAIT;
            end else begin
                wd     <= '0;
                resume <= 1'b0;
                if (BR_TAKEN) begin
                    state <= RUN;
                    cnt   <= '0;
                end else if (state == MEM_WAIT) begin
                    state <= resume ? LU_STALL : RUN;
                end else if (lu_req) begin
                    cnt   <= lu_next_cnt;
                    state <= (lu_next_cnt == 2'd0) ? RUN : LU_STALL;
                end
            end
        end
    end

`ifdef PERF_CNT_EN
    logic stall_cyc;
    logic flush_cyc;
    logic mwait_cyc;

    always_comb begin
        stall_cyc = ~RST & ~mem_stall & ~BR_TAKEN & lu_req;
        flush_cyc = ~RST & ~mem_stall & BR_TAKEN;
        mwait_cyc = ~RST & mem_stall;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
            MWAIT_CNT <= '0;
        end else begin
            if (stall_cyc && STALL_CNT != '1) begin
                STALL_CNT <= STALL_CNT + 1'b1;
            end
            if (flush_cyc && FLUSH_CNT != '1) begin
                FLUSH_CNT <= FLUSH_CNT + 1'b1;
            end
            if (mwait_cyc && MWAIT_CNT != '1) begin
                MWAIT_CNT <= MWAIT_CNT + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic vs. a bubble-count model.
module tb_pipe_ctrl;
    localparam int unsigned LU_CYC = 2;
    localparam int unsigned TMO    = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic LU_HAZ = 1'b0, BR_TAKEN = 1'b0, IMEM_RDY = 1'b1, DMEM_REQ = 1'b0, DMEM_ACK = 1'b0;
    logic PC_EN, FD_EN, DE_EN, EM_EN, MW_EN, FD_FLUSH, DE_FLUSH, MEM_ERR, BUSY;
`ifdef PERF_CNT_EN
    logic [31:0] STALL_CNT, FLUSH_CNT, MWAIT_CNT;
`endif

    pipe_ctrl #(.LU_STALL_CYC(LU_CYC), .MEM_TMO(TMO), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .LU_HAZ(LU_HAZ), .BR_TAKEN(BR_TAKEN), .IMEM_RDY(IMEM_RDY),
        .DMEM_REQ(DMEM_REQ), .DMEM_ACK(DMEM_ACK), .PC_EN(PC_EN), .FD_EN(FD_EN), .DE_EN(DE_EN),
        .EM_EN(EM_EN), .MW_EN(MW_EN), .FD_FLUSH(FD_FLUSH), .DE_FLUSH(DE_FLUSH),
        .MEM_ERR(MEM_ERR),
`ifdef PERF_CNT_EN
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT), .MWAIT_CNT(MWAIT_CNT),
`endif
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [8:0]  outs;
        logic [95:0] perf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc_no = 0;

    // Model: bubbles still owed to a load-use hazard, plus memory-wait bookkeeping
    int          owed = 0;
    bit          in_mem = 1'b0;
    int          wait_n = 0;
    bit          err = 1'b0;
    int unsigned p_stall = 0, p_flush = 0, p_mwait = 0;

    task automatic step(input bit rst, input bit lu, input bit br, input bit imem,
                        input bit req, input bit ack);
        exp_t       e;
        logic [6:0] ctl;
        bit         busy;
        @(posedge CLK);
        #1;
        RST = rst; LU_HAZ = lu; BR_TAKEN = br; IMEM_RDY = imem; DMEM_REQ = req; DMEM_ACK = ack;
        e.perf = {p_stall, p_flush, p_mwait};
        e.cyc  = cyc_no;
        cyc_no++;
        busy = in_mem || (owed > 0);
        if (rst) begin
            ctl = 7'b0000011;
            owed = 0; in_mem = 1'b0; wait_n = 0; err = 1'b0;
            p_stall = 0; p_flush = 0; p_mwait = 0;
        end else if (req && !ack) begin
            ctl = 7'b0000000;
            in_mem = 1'b1;
            wait_n++;
            if (wait_n >= TMO) err = 1'b1;
            p_mwait++;
        end else begin
            wait_n = 0;
            if (br) begin
                ctl = 7'b1111111;
                owed = 0;
                in_mem = 1'b0;
                p_flush++;
            end else if (in_mem) begin
                ctl = 7'b1111100;
                in_mem = 1'b0;
            end else if (owed > 0 || lu) begin
                ctl = 7'b0011101;
                owed = (owed > 0) ? owed - 1 : int'(LU_CYC) - 1;
                p_stall++;
            end else if (!imem) begin
                ctl = 7'b0111110;
            end else begin
                ctl = 7'b1111100;
            end
        end
        e.outs = {ctl, err, busy};
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin : monitor
        exp_t       e;
        logic [8:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {PC_EN, FD_EN, DE_EN, EM_EN, MW_EN, FD_FLUSH, DE_FLUSH, MEM_ERR, BUSY};
            n_chk++;
            if (act !== e.outs) begin
                n_fail++;
                $display("FAIL ctl cyc%0d: got %b want %b (pc fd de em mw fdf def err busy)",
                         e.cyc, act, e.outs);
            end
`ifdef PERF_CNT_EN
            n_chk++;
            if ({STALL_CNT, FLUSH_CNT, MWAIT_CNT} !== e.perf) begin
                n_fail++;
                $display("FAIL perf cyc%0d: got %0d/%0d/%0d want %0d/%0d/%0d", e.cyc,
                         STALL_CNT, FLUSH_CNT, MWAIT_CNT,
                         e.perf[95:64], e.perf[63:32], e.perf[31:0]);
            end
`endif
        end
    end

    initial begin
        // T1 reset held three cycles, then idle
        repeat (3) step(1, 0, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0, 0);
        // T2 single load-use hazard
        step(0, 1, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0, 0);
        // T3 hazard and taken branch together
        step(0, 1, 1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0, 0);
        // fetch bubble
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // T4 four wait cycles then ACK
        repeat (4) step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 1);
        repeat (2) step(0, 0, 0, 1, 0, 0);
        // T6 wait pre-empting the second stall cycle
        step(0, 1, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 1);
        repeat (3) step(0, 0, 0, 1, 0, 0);
        // T5 watchdog expiry, sticky error, cleared by reset
        repeat (10) step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 1);
        repeat (3) step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0, 0);
        // reset in the middle of a stall
        step(0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0, 0);
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 149) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 6) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge CLK);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
